// File: rtl/seg7_pkg.sv
// seg7_pkg: segment indices, lit patterns for hex digits and decode status shared by 7-seg logic
//   Patterns are lit-high (1 = segment on), bit order {g,f,e,d,c,b,a}.
package seg7_pkg;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam logic [6:0] SEG_PAT_0 = 7'h3F;
    localparam logic [6:0] SEG_PAT_1 = 7'h06;
    localparam logic [6:0] SEG_PAT_2 = 7'h5B;
    localparam logic [6:0] SEG_PAT_3 = 7'h4F;
    localparam logic [6:0] SEG_PAT_4 = 7'h66;
    localparam logic [6:0] SEG_PAT_5 = 7'h6D;
    localparam logic [6:0] SEG_PAT_6 = 7'h7D;
    localparam logic [6:0] SEG_PAT_7 = 7'h07;
    localparam logic [6:0] SEG_PAT_8 = 7'h7F;
    localparam logic [6:0] SEG_PAT_9 = 7'h67;
    localparam logic [6:0] SEG_PAT_A = 7'h77;
    localparam logic [6:0] SEG_PAT_B = 7'h7F;
    localparam logic [6:0] SEG_PAT_C = 7'h39;
    localparam logic [6:0] SEG_PAT_D = 7'h3F;
    localparam logic [6:0] SEG_PAT_E = 7'h79;
    localparam logic [6:0] SEG_PAT_F = 7'h71;
    typedef struct packed {
        logic valid;
        logic blank;
        logic ambig;
        logic illegal;
    } seg_status_t;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational lit pattern -> hex nibble and decode status
//   lit     in  7  lit segments {g,f,e,d,c,b,a}, 1 = on
//   nibble  out 4  decoded value (0 when blank or illegal)
//   status  out    {valid, blank, ambig, illegal}
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0]  lit,
    output logic [3:0]  nibble,
    output seg_status_t status
);
    // B shares the 8 pattern and D shares the 0 pattern, so those two decode as 8/0 flagged ambiguous
    always_comb begin
        nibble         = 4'h0;
        status.blank   = 1'b0;
        status.ambig   = 1'b0;
        status.illegal = 1'b0;
        case (lit)
            SEG_PAT_0: begin nibble = 4'h0; status.ambig = 1'b1; end
            SEG_PAT_1: nibble = 4'h1;
            SEG_PAT_2: nibble = 4'h2;
            SEG_PAT_3: nibble = 4'h3;
            SEG_PAT_4: nibble = 4'h4;
            SEG_PAT_5: nibble = 4'h5;
            SEG_PAT_6: nibble = 4'h6;
            SEG_PAT_7: nibble = 4'h7;
            SEG_PAT_8: begin nibble = 4'h8; status.ambig = 1'b1; end
            SEG_PAT_9: nibble = 4'h9;
            SEG_PAT_A: nibble = 4'hA;
            SEG_PAT_C: nibble = 4'hC;
            SEG_PAT_E: nibble = 4'hE;
            SEG_PAT_F: nibble = 4'hF;
            7'h00:     status.blank = 1'b1;
            default:   status.illegal = 1'b1;
        endcase
        status.valid = !(status.blank || status.illegal);
    end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: monitors a multiplexed active-low 4-digit 7-seg bus and recovers each digit
//   clk, rst_n      clock, async active-low reset
//   seg_n[6:0]      segment pins {g..a}, 0 = lit
//   an_n[3:0]       anode pins, 0 = selected
//   digits[15:0]    last nibble captured per digit {d3,d2,d1,d0}
//   digit_valid, blank, ambig, illegal [3:0]  per-digit status of the last capture
//   frame_stb       pulse when all four digits captured since the previous pulse
//   multi_an_err    pulse when a settled input has more than one anode low
//   stale           set after TIMEOUT_CYCLES without a capture
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  blank,
    output logic [3:0]  ambig,
    output logic [3:0]  illegal,
    output logic        frame_stb,
    output logic        multi_an_err,
    output logic        stale
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [6:0]    seg_m, seg_s, seg_p;
    logic [3:0]    an_m, an_s, an_p;
    logic [SW-1:0] stable_cnt;
    logic [TW-1:0] idle_cnt;
    logic [3:0]    seen, seen_nx, sel;
    logic          same, settle, one_hot, cap, time_out;
    logic [3:0]    nibble;
    seg_status_t   status;
    assign sel      = ~an_s;
    assign same     = {an_s, seg_s} == {an_p, seg_p};
    // settle is true only on the single cycle the counter steps onto SETTLE_CYCLES
    assign settle   = same && stable_cnt == SW'(SETTLE_CYCLES - 1);
    assign one_hot  = sel != 4'h0 && (sel & (sel - 4'd1)) == 4'h0;
    assign cap      = settle && one_hot;
    assign time_out = !cap && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign seen_nx  = seen | (cap ? sel : 4'h0);
    seg7_pattern_decode u_dec (
        .lit    (~seg_s),
        .nibble (nibble),
        .status (status)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m        <= '0;
            seg_s        <= '0;
            seg_p        <= '0;
            an_m         <= '0;
            an_s         <= '0;
            an_p         <= '0;
            stable_cnt   <= '0;
            idle_cnt     <= '0;
            seen         <= '0;
            digits       <= '0;
            digit_valid  <= '0;
            blank        <= '0;
            ambig        <= '0;
            illegal      <= '0;
            frame_stb    <= 1'b0;
            multi_an_err <= 1'b0;
            stale        <= 1'b0;
        end else begin
            seg_m        <= seg_n;
            seg_s        <= seg_m;
            seg_p        <= seg_s;
            an_m         <= an_n;
            an_s         <= an_m;
            an_p         <= an_s;
            stable_cnt   <= !same ? '0 : stable_cnt == SW'(SETTLE_CYCLES) ? stable_cnt : stable_cnt + 1'b1;
            idle_cnt     <= cap ? '0 : idle_cnt == TW'(TIMEOUT_CYCLES) ? idle_cnt : idle_cnt + 1'b1;
            multi_an_err <= settle && sel != 4'h0 && !one_hot;
            frame_stb    <= seen_nx == 4'hF;
            seen         <= (time_out || seen_nx == 4'hF) ? 4'h0 : seen_nx;
            stale        <= cap ? 1'b0 : time_out ? 1'b1 : stale;
            for (int i = 0; i < 4; i++) begin
                if (cap && sel[i]) begin
                    digits[4*i +: 4] <= nibble;
                    digit_valid[i]   <= status.valid;
                    blank[i]         <= status.blank;
                    ambig[i]         <= status.ambig;
                    illegal[i]       <= status.illegal;
                end else if (time_out) begin
                    digit_valid[i]   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: scoreboard bench for seg7_scan_capture (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64)
module tb_seg7_scan_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic [15:0] digits;
    logic [3:0]  digit_valid, blank, ambig, illegal;
    logic        frame_stb, multi_an_err, stale;
    int          tests = 0, fails = 0, frames = 0, errs = 0;
    logic [9:0]  sb[$];

    seg7_scan_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_n        (seg_n),
        .an_n         (an_n),
        .digits       (digits),
        .digit_valid  (digit_valid),
        .blank        (blank),
        .ambig        (ambig),
        .illegal      (illegal),
        .frame_stb    (frame_stb),
        .multi_an_err (multi_an_err),
        .stale        (stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (frame_stb) frames++;
        if (multi_an_err) errs++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {nibble, valid, blank, ambig, illegal} for an active-low segment bus value
    function automatic logic [7:0] ref_dec(input logic [6:0] s);
        case (s)
            7'b1000000: return 8'h0A;
            7'b1111001: return 8'h18;
            7'b0100100: return 8'h28;
            7'b0110000: return 8'h38;
            7'b0011001: return 8'h48;
            7'b0010010: return 8'h58;
            7'b0000010: return 8'h68;
            7'b1111000: return 8'h78;
            7'b0000000: return 8'h8A;
            7'b0011000: return 8'h98;
            7'b0001000: return 8'hA8;
            7'b1000110: return 8'hC8;
            7'b0000110: return 8'hE8;
            7'b0001110: return 8'hF8;
            7'b1111111: return 8'h04;
            default:    return 8'h01;
        endcase
    endfunction

    // called at a negedge; the capture is due on the 7th rising edge after the pins change
    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int hold, input bit exp_cap);
        logic [9:0] e;
        an_n  = an;
        seg_n = seg;
        if (exp_cap)
            for (int i = 0; i < 4; i++)
                if (!an[i]) sb.push_back({2'(i), ref_dec(seg)});
        for (int c = 1; c <= hold; c++) begin
            @(negedge clk);
            if (c == 7)
                while (sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("nib d%0d seg=%b", e[9:8], seg), 64'(digits[4*e[9:8] +: 4]), 64'(e[7:4]));
                    check($sformatf("stat d%0d seg=%b", e[9:8], seg),
                          64'({digit_valid[e[9:8]], blank[e[9:8]], ambig[e[9:8]], illegal[e[9:8]]}), 64'(e[3:0]));
                end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        show(4'b1110, 7'b1111001, 8, 1'b1);
        show(4'b1101, 7'b0100100, 3, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("reset_async", {digits, digit_valid, blank, ambig, illegal, frame_stb, multi_an_err, stale}, 64'h0);
        an_n  = 4'hF;
        seg_n = 7'h7F;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        frames = 0;
        repeat (20) @(negedge clk);
        check("no_frame_after_reset", 64'(frames), 64'd0);
        check("digits_after_reset", 64'(digits), 64'h0);

        an_n  = 4'b0111;
        seg_n = 7'b0100100;
        repeat (6) @(negedge clk);
        check("t2_before_edge7", 64'(digit_valid), 64'h0);
        @(negedge clk);
        check("t2_digit3", 64'(digits[15:12]), 64'h2);
        check("t2_valid", 64'(digit_valid), 64'h8);
        repeat (3) @(negedge clk);

        frames = 0;
        show(4'b1110, 7'b1111001, 8, 1'b1);
        show(4'b1101, 7'b0100100, 8, 1'b1);
        show(4'b1011, 7'b0110000, 8, 1'b1);
        show(4'b0111, 7'b0011001, 8, 1'b1);
        check("t3_digits", 64'(digits), 64'h4321);
        check("t3_valid", 64'(digit_valid), 64'hF);
        check("t3_frames", 64'(frames), 64'd1);

        an_n  = 4'hF;
        seg_n = 7'h7F;
        repeat (62) @(negedge clk);
        check("t6_stale_early", 64'(stale), 64'd0);
        @(negedge clk);
        check("t6_stale", 64'(stale), 64'd1);
        check("t6_valid_cleared", 64'(digit_valid), 64'h0);
        check("t6_digits_hold", 64'(digits), 64'h4321);

        show(4'b1110, 7'b0000000, 8, 1'b1);
        check("t6_stale_cleared", 64'(stale), 64'd0);
        show(4'b1110, 7'b1000000, 8, 1'b1);
        show(4'b1110, 7'b1111111, 8, 1'b1);
        check("t4_digits", 64'(digits), 64'h4320);

        errs = 0;
        show(4'b0011, 7'b0100100, 10, 1'b0);
        check("t5_multi_an_err", 64'(errs), 64'd1);
        check("t5_digits_hold", 64'(digits), 64'h4320);
        for (int k = 0; k < 10; k++) show(4'b1110, k[0] ? 7'b0100100 : 7'b1111001, 2, 1'b0);
        an_n  = 4'hF;
        seg_n = 7'h7F;
        repeat (10) @(negedge clk);
        check("t5_toggle_nocap", 64'({digit_valid[0], blank[0]}), 64'b01);
        check("t5_toggle_digits", 64'(digits), 64'h4320);
        check("t5_no_more_err", 64'(errs), 64'd1);

        for (int s = 0; s < 128; s++) show(4'b1101, 7'(s), 8, 1'b1);
        check("sweep_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
